// File: rtl/ring_mon_pkg.sv
// rtl/ring_mon_pkg.sv - shared state and error-code definitions for the ring phase monitor
package ring_mon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ACQUIRE = 2'b01,
    LOCKED  = 2'b10,
    FAULT   = 2'b11
  } mon_state_t;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_ONEHOT = 2'b01;
  localparam logic [1:0] ERR_JUMP   = 2'b10;
  localparam logic [1:0] ERR_STALL  = 2'b11;

endpackage

// File: rtl/ring_onehot_enc.sv
// rtl/ring_onehot_enc.sv - one-hot detector and binary index encoder
module ring_onehot_enc #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  vec,
  output logic          onehot,
  output logic [IW-1:0] idx
);

  localparam int CW = $clog2(N + 1);

  logic [CW-1:0] cnt;

  // idx is only meaningful when onehot is set; multi-hot inputs OR their indices
  always_comb begin
    cnt = '0;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        cnt = cnt + CW'(1);
        idx = idx | IW'(i);
      end
    end
    onehot = (cnt == CW'(1));
  end

endmodule

// File: rtl/ring_phase_monitor.sv
// rtl/ring_phase_monitor.sv - validates a one-hot ring counter, tracks lock/fault and revolutions
module ring_phase_monitor
  import ring_mon_pkg::*;
#(
  parameter int N           = 4,
  parameter int LOCK_CYCLES = 3,
  parameter int STALL_MAX   = 8,
  parameter int REV_W       = 8
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic [N-1:0]         q_in,
  output logic [$clog2(N)-1:0] phase,
  output logic                 phase_valid,
  output logic                 lock,
  output logic                 fault,
  output logic [1:0]           err_code,
  output logic [REV_W-1:0]     rev_count
);

  localparam int PW = $clog2(N);
  localparam int AW = $clog2(LOCK_CYCLES + 1);
  localparam int SW = $clog2(STALL_MAX + 1);

  logic [N-1:0]  q_s, q_p;
  logic          s_onehot;
  logic [PW-1:0] s_idx;
  logic          is_adv, is_hold, is_jump;
  mon_state_t    state, state_nxt;
  logic [AW-1:0] acq_cnt, acq_nxt;
  logic [SW-1:0] stall_cnt, stall_nxt;
  logic          err_raise;
  logic [1:0]    err_val;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q_s <= '0;
      q_p <= '0;
    end else begin
      q_s <= q_in;
      q_p <= q_s;
    end
  end

  ring_onehot_enc #(.N(N), .IW(PW)) u_enc (
    .vec    (q_s),
    .onehot (s_onehot),
    .idx    (s_idx)
  );

  assign is_adv  = s_onehot && (q_s == {q_p[N-2:0], q_p[N-1]});
  assign is_hold = s_onehot && (q_s == q_p);
  assign is_jump = s_onehot && !is_adv && !is_hold;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= IDLE;
      acq_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      state     <= state_nxt;
      acq_cnt   <= acq_nxt;
      stall_cnt <= stall_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    acq_nxt   = acq_cnt;
    stall_nxt = stall_cnt;
    err_raise = 1'b0;
    err_val   = ERR_NONE;
    case (state)
      IDLE, FAULT: begin
        if (s_onehot) begin
          state_nxt = ACQUIRE;
          acq_nxt   = '0;
        end
      end
      ACQUIRE: begin
        if (!s_onehot) begin
          state_nxt = IDLE;
        end else if (is_adv) begin
          if (acq_cnt + AW'(1) == AW'(LOCK_CYCLES)) begin
            state_nxt = LOCKED;
            acq_nxt   = '0;
            stall_nxt = '0;
          end else begin
            acq_nxt = acq_cnt + AW'(1);
          end
        end else if (is_jump) begin
          acq_nxt = '0;
        end
      end
      LOCKED: begin
        // classes are mutually exclusive, so at most one error source fires
        if (!s_onehot) begin
          err_raise = 1'b1;
          err_val   = ERR_ONEHOT;
        end else if (is_jump) begin
          err_raise = 1'b1;
          err_val   = ERR_JUMP;
        end else if (is_hold) begin
          if (stall_cnt + SW'(1) == SW'(STALL_MAX)) begin
            err_raise = 1'b1;
            err_val   = ERR_STALL;
          end else begin
            stall_nxt = stall_cnt + SW'(1);
          end
        end else begin
          stall_nxt = '0;
        end
        if (err_raise) begin
          state_nxt = FAULT;
          stall_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    lock = (state == LOCKED);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      phase       <= '0;
      phase_valid <= 1'b0;
      fault       <= 1'b0;
      err_code    <= ERR_NONE;
      rev_count   <= '0;
    end else begin
      if (s_onehot) phase <= s_idx;
      phase_valid <= s_onehot;
      // only the first error after clr is recorded
      if (err_raise && !fault) begin
        fault    <= 1'b1;
        err_code <= err_val;
      end
      if (state == LOCKED && is_adv && q_s[0]) rev_count <= rev_count + REV_W'(1);
    end
  end

endmodule

// File: tb/tb_ring_phase_monitor.sv
// tb/tb_ring_phase_monitor.sv - self-checking bench for ring_phase_monitor
module tb_ring_phase_monitor;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       clr;
  logic [3:0] q_in;
  logic [1:0] phase;
  logic       phase_valid, lock, fault;
  logic [1:0] err_code;
  logic [7:0] rev_count;

  always #5 clk = ~clk;

  ring_phase_monitor #(.N(4), .LOCK_CYCLES(3), .STALL_MAX(8), .REV_W(8)) dut (
    .clk         (clk),
    .clr         (clr),
    .q_in        (q_in),
    .phase       (phase),
    .phase_valid (phase_valid),
    .lock        (lock),
    .fault       (fault),
    .err_code    (err_code),
    .rev_count   (rev_count)
  );

  int checks = 0;
  int failures = 0;

  localparam int M_IDLE = 0, M_ACQ = 1, M_LOCK = 2, M_FAULT = 3;
  logic [3:0] m_qs, m_qp;
  int m_mode, m_acq, m_stall, m_phase, m_pv, m_fault, m_err, m_rev;

  typedef struct {
    logic [3:0] q;
    int ph, pv, lk, ft, ec, rv;
  } vec_t;
  vec_t tbl [11];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int idx_of(input logic [3:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_qs = '0; m_qp = '0;
    m_mode = M_IDLE; m_acq = 0; m_stall = 0;
    m_phase = 0; m_pv = 0; m_fault = 0; m_err = 0; m_rev = 0;
  endtask

  task automatic raise_err(input int code);
    if (m_fault == 0) begin
      m_fault = 1;
      m_err = code;
    end
    m_mode = M_FAULT;
  endtask

  task automatic model_edge(input logic [3:0] v);
    bit oh, poh, adv, hold, jump;
    int ci, pi;
    oh   = ($countones(m_qs) == 1);
    poh  = ($countones(m_qp) == 1);
    ci   = idx_of(m_qs);
    pi   = idx_of(m_qp);
    adv  = oh && poh && (ci == (pi + 1) % N);
    hold = oh && (m_qs == m_qp);
    jump = oh && !adv && !hold;
    if (oh) m_phase = ci;
    m_pv = oh ? 1 : 0;
    if (m_mode == M_LOCK && adv && ci == 0) m_rev = (m_rev + 1) % 256;
    case (m_mode)
      M_ACQ: begin
        if (!oh) m_mode = M_IDLE;
        else if (adv) begin
          m_acq++;
          if (m_acq == 3) begin m_mode = M_LOCK; m_stall = 0; end
        end else if (jump) m_acq = 0;
      end
      M_LOCK: begin
        if (!oh) raise_err(1);
        else if (jump) raise_err(2);
        else if (hold) begin
          m_stall++;
          if (m_stall == 8) raise_err(3);
        end else m_stall = 0;
      end
      default: if (oh) begin m_mode = M_ACQ; m_acq = 0; end
    endcase
    m_qp = m_qs;
    m_qs = v;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".phase"}, int'(phase), m_phase);
    check({tag, ".phase_valid"}, int'(phase_valid), m_pv);
    check({tag, ".lock"}, int'(lock), (m_mode == M_LOCK) ? 1 : 0);
    check({tag, ".fault"}, int'(fault), m_fault);
    check({tag, ".err_code"}, int'(err_code), m_err);
    check({tag, ".rev_count"}, int'(rev_count), m_rev);
  endtask

  task automatic drive(input logic [3:0] v);
    q_in = v;
    @(posedge clk);
    model_edge(v);
    #1;
    compare_all("model");
  endtask

  // asynchronous clear between edges; outputs must drop without a clock
  task automatic pulse_clr();
    #2;
    clr = 1'b1;
    #1;
    model_reset();
    check("clr.lock", int'(lock), 0);
    check("clr.fault", int'(fault), 0);
    check("clr.err_code", int'(err_code), 0);
    check("clr.rev_count", int'(rev_count), 0);
    check("clr.phase_valid", int'(phase_valid), 0);
    check("clr.phase", int'(phase), 0);
    clr = 1'b0;
  endtask

  task automatic lock_up();
    drive(4'b0001); drive(4'b0010); drive(4'b0100); drive(4'b1000); drive(4'b0001);
    check("lock_up.lock", int'(lock), 1);
  endtask

  logic [3:0] bad_vals [5];
  logic [3:0] v;
  int cur, r;

  initial begin
    bad_vals = '{4'b0000, 4'b0011, 4'b0101, 4'b1100, 4'b1111};
    tbl[0]  = '{4'b0001, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{4'b0010, 0, 1, 0, 0, 0, 0};
    tbl[2]  = '{4'b0100, 1, 1, 0, 0, 0, 0};
    tbl[3]  = '{4'b1000, 2, 1, 0, 0, 0, 0};
    tbl[4]  = '{4'b0001, 3, 1, 1, 0, 0, 0};
    tbl[5]  = '{4'b0010, 0, 1, 1, 0, 0, 1};
    tbl[6]  = '{4'b0100, 1, 1, 1, 0, 0, 1};
    tbl[7]  = '{4'b0011, 2, 1, 1, 0, 0, 1};
    tbl[8]  = '{4'b0011, 2, 0, 0, 1, 1, 1};
    tbl[9]  = '{4'b0001, 2, 0, 0, 1, 1, 1};
    tbl[10] = '{4'b0010, 0, 1, 0, 1, 1, 1};

    clr = 1'b1;
    q_in = '0;
    #3;
    model_reset();
    check("reset.phase", int'(phase), 0);
    check("reset.phase_valid", int'(phase_valid), 0);
    check("reset.lock", int'(lock), 0);
    check("reset.fault", int'(fault), 0);
    check("reset.err_code", int'(err_code), 0);
    check("reset.rev_count", int'(rev_count), 0);
    clr = 1'b0;

    // outputs after each edge reflect the previous row's input
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].q);
      check($sformatf("tbl%0d.phase", i), int'(phase), tbl[i].ph);
      check($sformatf("tbl%0d.phase_valid", i), int'(phase_valid), tbl[i].pv);
      check($sformatf("tbl%0d.lock", i), int'(lock), tbl[i].lk);
      check($sformatf("tbl%0d.fault", i), int'(fault), tbl[i].ft);
      check($sformatf("tbl%0d.err_code", i), int'(err_code), tbl[i].ec);
      check($sformatf("tbl%0d.rev_count", i), int'(rev_count), tbl[i].rv);
    end

    // illegal jump, then re-acquire with sticky error
    pulse_clr();
    lock_up();
    drive(4'b0100);
    drive(4'b1000);
    check("jump.lock", int'(lock), 0);
    check("jump.fault", int'(fault), 1);
    check("jump.err_code", int'(err_code), 2);
    drive(4'b0001); drive(4'b0010); drive(4'b0100); drive(4'b1000);
    check("reacq.lock", int'(lock), 1);
    check("reacq.fault", int'(fault), 1);
    check("reacq.err_code", int'(err_code), 2);

    // 8 holds while locked -> stall
    pulse_clr();
    lock_up();
    for (int i = 0; i < 9; i++) drive(4'b0010);
    check("stall7.fault", int'(fault), 0);
    check("stall7.lock", int'(lock), 1);
    drive(4'b0010);
    check("stall8.fault", int'(fault), 1);
    check("stall8.err_code", int'(err_code), 3);
    check("stall8.lock", int'(lock), 0);

    // 7 holds then advance -> still locked
    pulse_clr();
    lock_up();
    for (int i = 0; i < 8; i++) drive(4'b0010);
    drive(4'b0100);
    drive(4'b1000);
    check("hold7.fault", int'(fault), 0);
    check("hold7.lock", int'(lock), 1);

    // non-one-hot in IDLE raises nothing
    pulse_clr();
    drive(4'b0000); drive(4'b1100); drive(4'b0000);
    check("idle.lock", int'(lock), 0);
    check("idle.fault", int'(fault), 0);
    check("idle.phase_valid", int'(phase_valid), 0);

    // clear mid-revolution while locked
    lock_up();
    drive(4'b0010);
    pulse_clr();

    // 256 locked revolutions wrap the counter
    lock_up();
    for (int k = 1; k <= 256; k++) begin
      drive(4'b0010); drive(4'b0100); drive(4'b1000); drive(4'b0001);
      if (k == 255) check("rev255", int'(rev_count), 255);
    end
    check("wrap.rev_count", int'(rev_count), 0);
    check("wrap.fault", int'(fault), 0);
    check("wrap.lock", int'(lock), 1);

    // randomized mostly-legal traffic against the model
    pulse_clr();
    cur = 0;
    for (int k = 0; k < 3000; k++) begin
      if (k % 400 == 399) pulse_clr();
      r = $urandom_range(0, 99);
      if (r < 75) begin
        cur = (cur + 1) % N;
        v = 4'(1 << cur);
      end else if (r < 85) begin
        v = 4'(1 << cur);
      end else if (r < 93) begin
        cur = $urandom_range(0, N - 1);
        v = 4'(1 << cur);
      end else begin
        v = bad_vals[$urandom_range(0, 4)];
      end
      drive(v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
